placer_load_port: RTL and testbench
===================================

PLACER_LOAD_PORT -- requirements
Module: placer_load_port

Interface
REQ-001 Parameter BUS_WIDTH, default 32: width of the load and unload data words.
REQ-002 Parameter N, default 16: problem size; sets PACKET_LENGTH = 8+N words per packet and NUM_OF_PACKETS = N+2 packets per bitstream.
REQ-003 Parameter UNLOAD_WORDS, default N: number of words streamed out per run.
REQ-004 Clock clk; reset reset, synchronous, active-high.
REQ-005 clk  in  1  rising-edge clock for all state.
REQ-006 reset  in  1  synchronous active-high reset.
REQ-007 load_enable_in  in  1  one-cycle strobe: marks the first word of a packet, or the start command once all packets are loaded.
REQ-008 load_in  in  BUS_WIDTH  load data word, sampled every cycle while receiving.
REQ-009 wr_valid  out  1  one-cycle write strobe toward the PE array.
REQ-010 wr_packet  out  clog2(NUM_OF_PACKETS)  packet index of the current write.
REQ-011 wr_word  out  clog2(PACKET_LENGTH)  word index within the packet.
REQ-012 wr_data  out  BUS_WIDTH  captured load word.
REQ-013 start  out  1  one-cycle pulse that launches placement.
REQ-014 done  in  1  array reports placement finished; level or pulse.
REQ-015 rd_addr  out  clog2(UNLOAD_WORDS)  result read address.
REQ-016 rd_data  in  BUS_WIDTH  result word, valid exactly 1 cycle after rd_addr.
REQ-017 complete  out  1  high while unload_out carries a valid result word.
REQ-018 unload_out  out  BUS_WIDTH  result word.
REQ-019 protocol_err  out  1  sticky protocol-error flag.

Function
REQ-020 FSM states: IDLE, RECV, ARMED, RUN, UNLOAD.
REQ-021 IDLE with load_enable_in=1: capture load_in as word 0 of the current packet and go to RECV.
REQ-022 IDLE without the strobe: hold; load_in is ignored.
REQ-023 RECV: capture load_in on each of the next PACKET_LENGTH-1 cycles as words 1..PACKET_LENGTH-1; the strobe is expected low throughout.
REQ-024 Every captured word produces exactly one wr_valid pulse, one cycle after capture, carrying that word's wr_packet, wr_word and wr_data.
REQ-025 After word PACKET_LENGTH-1 is captured, increment the packet count, then:
- go to ARMED if the count equals NUM_OF_PACKETS;
- otherwise return to IDLE.
REQ-026 Gaps of any length between packets are allowed.
REQ-027 Strobe received mid-packet in RECV:
- set protocol_err;
- discard the partial packet (words already written are not rolled back);
- treat the strobe word as word 0 of the same packet index.
REQ-028 ARMED with load_enable_in=1: pulse start for 1 cycle, go to RUN; load_in is ignored.
REQ-029 RUN: ignore load_enable_in; on done=1, go to UNLOAD and drive rd_addr=0.
REQ-030 UNLOAD: advance rd_addr by 1 per cycle from 0 to UNLOAD_WORDS-1.
REQ-031 UNLOAD output timing: complete=1 and unload_out=rd_data on exactly UNLOAD_WORDS consecutive cycles, starting 1 cycle after rd_addr=0.
REQ-032 After the last unload word: complete=0, packet count cleared, go to IDLE, ready for the next run.
REQ-033 Load strobes during RUN or UNLOAD: ignored and set protocol_err.
REQ-034 done is evaluated only in RUN.
REQ-035 Counters are unsigned and never wrap within a run; the packet index saturates at NUM_OF_PACKETS.
REQ-036 complete and wr_valid are never asserted in the same cycle.

Reset
REQ-037 Reset values:
- state=IDLE; packet and word counters 0;
- wr_valid=0, start=0, complete=0, protocol_err=0;
- wr_packet=0, wr_word=0, wr_data=0, unload_out=0, rd_addr=0.
REQ-038 Reset in any state, including mid-packet or mid-unload, takes effect at the next edge; no partial pulse follows it.
REQ-039 Reset is the only way to clear protocol_err.

Verification
REQ-040 Full load: N=4, BUS_WIDTH=16; 6 packets of 12 words, 20-cycle gaps, data = packet*16+word -> 72 wr_valid pulses in order; last pulse has wr_packet=5, wr_word=11, wr_data=0x5B; state ARMED; protocol_err=0.
REQ-041 Start and unload: after the full load, one strobe -> start pulses exactly once; done=1 -> complete high for exactly 4 cycles; unload_out follows rd_data for addresses 0,1,2,3; then IDLE.
REQ-042 Mid-packet strobe: strobe at word 5 of packet 2 -> protocol_err=1; wr_word restarts at 0 with wr_packet=2; bitstream still completes after 6 full packets.
REQ-043 Strobes out of phase: strobe during RUN -> no start, protocol_err=1; done held high longer than the unload -> exactly UNLOAD_WORDS words are unloaded.
REQ-044 Reset mid-operation: reset at word 7 of packet 3 -> all outputs at reset values next cycle; a fresh full load then succeeds from packet 0.
REQ-045 Back-to-back runs: second full load and run after the first unload -> identical wr_* sequence and unload count; complete returns to 0 between runs.

Source files
------------

// File: rtl/placer_load_port.sv
// ---------------------------------------------------------------------------
// placer_load_port
//
// Front door of the placer PE array. Receives a bitstream of NUM_OF_PACKETS
// packets (PACKET_LENGTH words each) on load_in, replays every captured word
// as a write toward the array, launches placement with a one-cycle start
// pulse, waits for done, then streams UNLOAD_WORDS result words back out.
//
// Ports
//   clk            rising-edge clock for all state
//   reset          synchronous, active-high reset
//   load_enable_in strobe: first word of a packet, or start command when armed
//   load_in        load data word
//   wr_valid       one-cycle write strobe toward the PE array
//   wr_packet      packet index of the current write
//   wr_word        word index within the packet
//   wr_data        captured load word
//   start          one-cycle placement launch pulse
//   done           placement finished (level or pulse), looked at only in RUN
//   rd_addr        result read address
//   rd_data        result word, valid one cycle after rd_addr
//   complete       high while unload_out carries a valid result word
//   unload_out     result word
//   protocol_err   sticky protocol-error flag, cleared only by reset
// ---------------------------------------------------------------------------
module placer_load_port #(
  parameter int BUS_WIDTH    = 32,
  parameter int N            = 16,
  parameter int UNLOAD_WORDS = N,
  localparam int PACKET_LENGTH  = 8 + N,
  localparam int NUM_OF_PACKETS = N + 2,
  localparam int PKT_W  = (NUM_OF_PACKETS > 1) ? $clog2(NUM_OF_PACKETS) : 1,
  localparam int WORD_W = (PACKET_LENGTH > 1) ? $clog2(PACKET_LENGTH) : 1,
  localparam int ADDR_W = (UNLOAD_WORDS > 1) ? $clog2(UNLOAD_WORDS) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load_enable_in,
  input  logic [BUS_WIDTH-1:0] load_in,
  output logic                 wr_valid,
  output logic [PKT_W-1:0]     wr_packet,
  output logic [WORD_W-1:0]    wr_word,
  output logic [BUS_WIDTH-1:0] wr_data,
  output logic                 start,
  input  logic                 done,
  output logic [ADDR_W-1:0]    rd_addr,
  input  logic [BUS_WIDTH-1:0] rd_data,
  output logic                 complete,
  output logic [BUS_WIDTH-1:0] unload_out,
  output logic                 protocol_err
);

  // The packet counter has to be able to hold NUM_OF_PACKETS itself
  // (saturation value), which needs one more code than wr_packet carries.
  localparam int CNT_W = $clog2(NUM_OF_PACKETS + 1);

  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(PACKET_LENGTH - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(UNLOAD_WORDS - 1);
  localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(NUM_OF_PACKETS);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    RECV   = 3'd1,
    ARMED  = 3'd2,
    RUN    = 3'd3,
    UNLOAD = 3'd4
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [CNT_W-1:0]  pkt_cnt;
  logic [WORD_W-1:0] word_cnt;   // index the next RECV capture will get

  logic              cap_en;
  logic [WORD_W-1:0] cap_word;
  logic              err_set;
  logic              start_nxt;
  logic              pkt_inc;
  logic              pkt_clr;

  // Packet count never runs past NUM_OF_PACKETS.
  function automatic logic [CNT_W-1:0] sat_inc_pkt(input logic [CNT_W-1:0] c);
    if (c >= FULL_CNT) begin
      return FULL_CNT;
    end
    return c + CNT_W'(1);
  endfunction

  // Word index following the one just captured; wraps to 0 after the last.
  function automatic logic [WORD_W-1:0] next_word(input logic [WORD_W-1:0] w);
    if (w == LAST_WORD) begin
      return '0;
    end
    return w + WORD_W'(1);
  endfunction

  // -------------------------------------------------------------------------
  // Stage 0: state decode
  // -------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    cap_en    = 1'b0;
    cap_word  = word_cnt;
    err_set   = 1'b0;
    start_nxt = 1'b0;
    pkt_inc   = 1'b0;
    pkt_clr   = 1'b0;

    case (state)
      IDLE: begin
        if (load_enable_in) begin
          cap_en    = 1'b1;
          cap_word  = '0;
          state_nxt = RECV;
        end
      end

      RECV: begin
        cap_en = 1'b1;
        if (load_enable_in) begin
          // Early strobe: the partial packet is abandoned and this word
          // restarts the same packet index.
          err_set  = 1'b1;
          cap_word = '0;
        end else if (word_cnt == LAST_WORD) begin
          pkt_inc   = 1'b1;
          state_nxt = (sat_inc_pkt(pkt_cnt) == FULL_CNT) ? ARMED : IDLE;
        end
      end

      ARMED: begin
        if (load_enable_in) begin
          start_nxt = 1'b1;
          state_nxt = RUN;
        end
      end

      RUN: begin
        if (load_enable_in) begin
          err_set = 1'b1;
        end
        if (done) begin
          state_nxt = UNLOAD;
        end
      end

      UNLOAD: begin
        if (load_enable_in) begin
          err_set = 1'b1;
        end
        if (rd_addr == LAST_ADDR) begin
          pkt_clr   = 1'b1;
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Stage 1: state, counters and registered outputs
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      word_cnt <= '0;
      pkt_cnt  <= '0;
    end else begin
      if (cap_en) begin
        word_cnt <= next_word(cap_word);
      end
      if (pkt_clr) begin
        pkt_cnt <= '0;
      end else if (pkt_inc) begin
        pkt_cnt <= sat_inc_pkt(pkt_cnt);
      end
    end
  end

  // Each capture shows up on the write port exactly one cycle later.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_valid  <= 1'b0;
      wr_packet <= '0;
      wr_word   <= '0;
      wr_data   <= '0;
    end else begin
      wr_valid <= cap_en;
      if (cap_en) begin
        wr_packet <= pkt_cnt[PKT_W-1:0];
        wr_word   <= cap_word;
        wr_data   <= load_in;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      start        <= 1'b0;
      protocol_err <= 1'b0;
    end else begin
      start        <= start_nxt;
      protocol_err <= protocol_err | err_set;
    end
  end

  // rd_addr sits at 0 outside UNLOAD, so entering UNLOAD presents address 0
  // on its first cycle. complete trails the address by one cycle, matching
  // the one-cycle read latency of rd_data.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_addr  <= '0;
      complete <= 1'b0;
    end else begin
      complete <= (state == UNLOAD);
      if (state == UNLOAD && rd_addr != LAST_ADDR) begin
        rd_addr <= rd_addr + ADDR_W'(1);
      end else begin
        rd_addr <= '0;
      end
    end
  end

  assign unload_out = complete ? rd_data : '0;

endmodule

// File: tb/tb_placer_load_port.sv
// ---------------------------------------------------------------------------
// tb_placer_load_port
//
// Self-checking bench for placer_load_port (N=4, BUS_WIDTH=16). The
// reference model is a queue of expected write beats built from the packet
// rules while the stimulus is driven, plus a small result memory that plays
// the array's read port. A negedge monitor retires beats and result words.
// ---------------------------------------------------------------------------
module tb_placer_load_port;

  localparam int BW = 16;
  localparam int NN = 4;
  localparam int UW = NN;
  localparam int PL = 8 + NN;
  localparam int NP = NN + 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          load_enable_in = 1'b0;
  logic [BW-1:0] load_in = '0;
  logic          done = 1'b0;
  logic [BW-1:0] rd_data = '0;

  logic          wr_valid;
  logic [2:0]    wr_packet;
  logic [3:0]    wr_word;
  logic [BW-1:0] wr_data;
  logic          start;
  logic [1:0]    rd_addr;
  logic          complete;
  logic [BW-1:0] unload_out;
  logic          protocol_err;

  placer_load_port #(
    .BUS_WIDTH(BW),
    .N(NN)
  ) dut (
    .clk(clk),
    .reset(reset),
    .load_enable_in(load_enable_in),
    .load_in(load_in),
    .wr_valid(wr_valid),
    .wr_packet(wr_packet),
    .wr_word(wr_word),
    .wr_data(wr_data),
    .start(start),
    .done(done),
    .rd_addr(rd_addr),
    .rd_data(rd_data),
    .complete(complete),
    .unload_out(unload_out),
    .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  // Result memory with one cycle of read latency.
  logic [BW-1:0] mem [UW];
  always @(posedge clk) rd_data <= mem[rd_addr];

  int n_checks = 0;
  int n_err = 0;
  int wr_cnt = 0;
  int wbase = 0;
  int start_cnt = 0;
  int ucnt = 0;
  int ubase = 0;
  logic [22:0] exp_q [$];
  logic [22:0] last_wr = '0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Monitor: retires write beats against the model queue, counts start
  // pulses and checks each result word against the memory contents.
  always @(negedge clk) begin
    int idx;
    if (wr_valid || complete) chk("wr_complete_overlap", 32'(wr_valid & complete), 0);
    if (wr_valid) begin
      wr_cnt++;
      chk("wr_expected", 32'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        logic [22:0] e;
        e = exp_q.pop_front();
        chk("wr_beat", 32'({wr_packet, wr_word, wr_data}), 32'(e));
      end
      last_wr = {wr_packet, wr_word, wr_data};
    end
    if (start) start_cnt++;
    if (complete) begin
      idx = ucnt - ubase;
      chk("unload_idx_range", 32'(idx < UW), 1);
      if (idx < UW) chk("unload_data", 32'(unload_out), 32'(mem[idx]));
      ucnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic en, input logic [BW-1:0] d);
    load_enable_in = en;
    load_in = d;
    tick();
    load_enable_in = 1'b0;
    load_in = 16'($urandom);
  endtask

  task automatic send_words(input int p, input int nwords, input bit rnd);
    for (int w = 0; w < nwords; w++) begin
      logic [BW-1:0] d;
      d = rnd ? 16'($urandom) : 16'(p * 16 + w);
      exp_q.push_back({3'(p), 4'(w), d});
      drive(w == 0, d);
    end
  endtask

  task automatic gap(input bit fixed);
    int g;
    g = fixed ? 20 : int'($urandom_range(0, 25));
    repeat (g) drive(1'b0, 16'($urandom));
  endtask

  // Full bitstream; optionally abandons packet abort_pkt after abort_at
  // words by restarting it with a fresh strobe.
  task automatic load_all(input bit rnd, input bit fixed_gap, input int abort_pkt, input int abort_at);
    wbase = wr_cnt;
    for (int p = 0; p < NP; p++) begin
      if (p == abort_pkt) send_words(p, abort_at, rnd);
      send_words(p, PL, rnd);
      gap(fixed_gap);
    end
    repeat (2) tick();
  endtask

  task automatic check_load(input int exp_cnt, input int exp_err);
    chk("load_q_empty", 32'(exp_q.size()), 0);
    chk("load_wr_cnt", 32'(wr_cnt - wbase), 32'(exp_cnt));
    chk("load_err", 32'(protocol_err), 32'(exp_err));
    chk("load_no_start", 32'(start), 0);
  endtask

  task automatic do_run(input bit run_strobe, input int hold);
    int s0;
    for (int i = 0; i < UW; i++) mem[i] = 16'($urandom);
    s0 = start_cnt;
    drive(1'b1, 16'($urandom));
    tick();
    chk("start_once", 32'(start_cnt - s0), 1);
    if (run_strobe) begin
      drive(1'b1, 16'($urandom));
      tick();
      chk("run_strobe_no_start", 32'(start_cnt - s0), 1);
      chk("run_strobe_err", 32'(protocol_err), 1);
    end
    chk("complete_pre", 32'(complete), 0);
    ubase = ucnt;
    done = 1'b1;
    repeat (hold) tick();
    done = 1'b0;
    for (int i = 0; i < 20 && (ucnt - ubase) < UW; i++) tick();
    repeat (4) tick();
    chk("unload_count", 32'(ucnt - ubase), UW);
    chk("complete_post", 32'(complete), 0);
    chk("run_start_total", 32'(start_cnt - s0), 1);
  endtask

  task automatic chk_reset_vals();
    chk("rst_wr_valid", 32'(wr_valid), 0);
    chk("rst_wr_packet", 32'(wr_packet), 0);
    chk("rst_wr_word", 32'(wr_word), 0);
    chk("rst_wr_data", 32'(wr_data), 0);
    chk("rst_start", 32'(start), 0);
    chk("rst_complete", 32'(complete), 0);
    chk("rst_protocol_err", 32'(protocol_err), 0);
    chk("rst_rd_addr", 32'(rd_addr), 0);
    chk("rst_unload_out", 32'(unload_out), 0);
  endtask

  initial begin
    for (int i = 0; i < UW; i++) mem[i] = '0;
    reset = 1'b1;
    repeat (3) tick();
    chk_reset_vals();
    reset = 1'b0;
    tick();

    // Full load with the reference data pattern and fixed gaps, plain run.
    load_all(1'b0, 1'b1, -1, 0);
    check_load(NP * PL, 0);
    chk("last_wr", 32'(last_wr), 32'({3'd5, 4'd11, 16'h005B}));
    do_run(1'b0, 1);
    chk("err_after_run1", 32'(protocol_err), 0);

    // Back-to-back second run, done held well past the unload.
    load_all(1'b0, 1'b0, -1, 0);
    check_load(NP * PL, 0);
    do_run(1'b0, 10);

    // Random data, mid-packet strobe at word 5 of packet 2, strobe in RUN.
    load_all(1'b1, 1'b0, 2, 5);
    check_load(NP * PL + 5, 1);
    do_run(1'b1, 3);

    // Reset at word 7 of packet 3, then a fresh load from packet 0.
    wbase = wr_cnt;
    for (int p = 0; p < 3; p++) begin
      send_words(p, PL, 1'b1);
      gap(1'b0);
    end
    send_words(3, 7, 1'b1);
    reset = 1'b1;
    load_in = 16'($urandom);
    tick();
    chk_reset_vals();
    reset = 1'b0;
    tick();
    chk("rst_q_empty", 32'(exp_q.size()), 0);
    load_all(1'b1, 1'b0, -1, 0);
    check_load(NP * PL, 0);
    do_run(1'b0, 2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
